// File: rtl/lsf_event_sender.sv
// HEG-side event sender for the LSF input interface: one ROI, up to MAX_HITS hit
// strobes throttled by the LSF almost-full flags, an EOF pulse, then a settling gap.
module lsf_event_sender #(
  parameter int HIT_W    = 32,
  parameter int ROI_W    = 32,
  parameter int MAX_HITS = 32,
  parameter int CNT_W    = 6,
  parameter int TIMEOUT  = 1023,
  parameter int EOF_GAP  = 4
) (
  input  logic             clock,
  input  logic             resetbar,
  input  logic [ROI_W-1:0] i_roi,
  input  logic             i_roi_valid,
  output logic             o_roi_ready,
  input  logic [HIT_W-1:0] i_hit,
  input  logic             i_hit_valid,
  input  logic             i_hit_last,
  output logic             o_hit_ready,
  input  logic             i_roi_af,
  input  logic             i_hit_af,
  output logic [ROI_W-1:0] roi,
  output logic             roi_we,
  output logic [HIT_W-1:0] mdt_hit,
  output logic             mdt_hit_we,
  output logic             o_eof,
  output logic [CNT_W-1:0] o_hit_count,
  output logic             o_overflow,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (EOF_GAP < 1) ? 1 : $clog2(EOF_GAP + 1);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HITS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(EOF_GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HITS = 2'd1,
    S_EOF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drop;
  logic             r_by_tmo;
  logic [TMO_W-1:0] r_tmo;
  logic [GAP_W-1:0] r_gap;
  logic [ROI_W-1:0] r_roi;
  logic             r_roi_we;
  logic [HIT_W-1:0] r_hit;
  logic             r_hit_we;
  logic             r_eof;
  logic [CNT_W-1:0] r_hit_count;
  logic             r_overflow;
  logic             r_timeout;

  logic w_roi_hs;
  logic w_hit_hs;

  assign o_roi_ready = (r_state == S_IDLE) & ~i_roi_af;
  assign o_hit_ready = (r_state == S_HITS) & ~i_hit_af;
  assign w_roi_hs    = i_roi_valid & o_roi_ready;
  assign w_hit_hs    = i_hit_valid & o_hit_ready;

  assign roi         = r_roi;
  assign roi_we      = r_roi_we;
  assign mdt_hit     = r_hit;
  assign mdt_hit_we  = r_hit_we;
  assign o_eof       = r_eof;
  assign o_hit_count = r_hit_count;
  assign o_overflow  = r_overflow;
  assign o_timeout   = r_timeout;
  assign o_busy      = (r_state != S_IDLE);

  // Event sequencer: strobes default low and are raised for exactly one cycle per transfer.
  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_by_tmo    <= 1'b0;
      r_tmo       <= '0;
      r_gap       <= '0;
      r_roi       <= '0;
      r_roi_we    <= 1'b0;
      r_hit       <= '0;
      r_hit_we    <= 1'b0;
      r_eof       <= 1'b0;
      r_hit_count <= '0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_roi_we  <= 1'b0;
      r_hit_we  <= 1'b0;
      r_eof     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_roi_hs) begin
            r_roi    <= i_roi;
            r_roi_we <= 1'b1;
            r_cnt    <= '0;
            r_drop   <= 1'b0;
            r_by_tmo <= 1'b0;
            r_tmo    <= '0;
            r_state  <= S_HITS;
          end
        end
        S_HITS: begin
          if (w_hit_hs) begin
            r_tmo <= '0;
            if (r_cnt < MAX_C) begin
              r_hit    <= i_hit;
              r_hit_we <= 1'b1;
              r_cnt    <= r_cnt + CNT_W'(1);
            end else begin
              r_drop <= 1'b1;
            end
            if (i_hit_last) begin
              r_state <= S_EOF;
            end
          end else if (r_tmo == TMO_LAST) begin
            // This is the TIMEOUT-th cycle without a hit handshake.
            r_by_tmo <= 1'b1;
            r_state  <= S_EOF;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_EOF: begin
          r_eof       <= 1'b1;
          r_timeout   <= r_by_tmo;
          r_hit_count <= r_cnt;
          r_overflow  <= r_drop;
          r_gap       <= '0;
          r_state     <= S_GAP;
        end
        S_GAP: begin
          // The o_eof cycle is gap cycle 0, so IDLE starts EOF_GAP+1 cycles after o_eof.
          if (r_gap == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsf_event_sender.sv
// Randomized scoreboard bench for lsf_event_sender: the driver predicts LSF writes from
// event-level rules, a negedge monitor pops and compares whenever the DUT strobes.
module tb_lsf_event_sender;

  localparam int HIT_W    = 32;
  localparam int ROI_W    = 32;
  localparam int MAX_HITS = 32;
  localparam int CNT_W    = 6;
  localparam int TIMEOUT  = 1023;
  localparam int EOF_GAP  = 4;

  logic             clock = 1'b0;
  logic             resetbar;
  logic [ROI_W-1:0] i_roi;
  logic             i_roi_valid;
  logic             o_roi_ready;
  logic [HIT_W-1:0] i_hit;
  logic             i_hit_valid;
  logic             i_hit_last;
  logic             o_hit_ready;
  logic             i_roi_af;
  logic             i_hit_af;
  logic [ROI_W-1:0] roi;
  logic             roi_we;
  logic [HIT_W-1:0] mdt_hit;
  logic             mdt_hit_we;
  logic             o_eof;
  logic [CNT_W-1:0] o_hit_count;
  logic             o_overflow;
  logic             o_timeout;
  logic             o_busy;

  lsf_event_sender #(
    .HIT_W(HIT_W), .ROI_W(ROI_W), .MAX_HITS(MAX_HITS), .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT), .EOF_GAP(EOF_GAP)
  ) dut (
    .clock(clock), .resetbar(resetbar),
    .i_roi(i_roi), .i_roi_valid(i_roi_valid), .o_roi_ready(o_roi_ready),
    .i_hit(i_hit), .i_hit_valid(i_hit_valid), .i_hit_last(i_hit_last), .o_hit_ready(o_hit_ready),
    .i_roi_af(i_roi_af), .i_hit_af(i_hit_af),
    .roi(roi), .roi_we(roi_we), .mdt_hit(mdt_hit), .mdt_hit_we(mdt_hit_we),
    .o_eof(o_eof), .o_hit_count(o_hit_count), .o_overflow(o_overflow),
    .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind: 0 = ROI write, 1 = hit write, 2 = end of event
  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cnt;
    bit          ovf;
    bit          tmo;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          last_eof_mon = -1000;
  logic [31:0] next_roi;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_exp(input int kind, input logic [31:0] data, input int cnt,
                                   input bit ovf, input bit tmo);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cnt  = cnt;
    e.ovf  = ovf;
    e.tmo  = tmo;
    exp_q.push_back(e);
  endfunction

  // Monitor: every LSF-side strobe must match the oldest prediction.
  always @(negedge clock) begin
    exp_t e;
    int   kind;
    if (!resetbar) begin
      last_eof_mon = -1000;
    end else begin
      if (o_timeout) chk("timeout_with_eof", {63'b0, o_eof}, 64'd1);
      if (roi_we || mdt_hit_we || o_eof) begin
        chk("strobe_exclusive", 64'($countones({roi_we, mdt_hit_we, o_eof})), 64'd1);
        kind = roi_we ? 0 : (mdt_hit_we ? 1 : 2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected no output", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", 64'(kind), 64'(e.kind));
          if (kind == 0) begin
            chk("roi_data", 64'(roi), 64'(e.data));
            chk("roi_after_gap", 64'(cyc - last_eof_mon >= EOF_GAP + 2), 64'd1);
          end else if (kind == 1) begin
            chk("hit_data", 64'(mdt_hit), 64'(e.data));
          end else begin
            chk("eof_hit_count", 64'(o_hit_count), 64'(e.cnt));
            chk("eof_overflow", {63'b0, o_overflow}, {63'b0, e.ovf});
            chk("eof_timeout", {63'b0, o_timeout}, {63'b0, e.tmo});
            last_eof_mon = cyc;
          end
        end
      end
    end
  end

  task automatic wait_eof(input int bound, output int ecyc);
    ecyc = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clock);
      if (o_eof) begin
        ecyc = cyc;
        break;
      end
    end
    if (ecyc < 0) begin
      checks++;
      errors++;
      $display("FAIL eof_wait: no o_eof within %0d cycles", bound);
    end
  endtask

  // One event: ROI, then n hits (n==0 means no hits, closed by timeout).
  // abort_after>0 asserts resetbar right after that many hits have been written.
  task automatic send_event(input int n, input int gap_pct, input int af_pct, input bit af_burst,
                            input bit hold_roi, input int abort_after,
                            output int roi_hs, output int ecyc);
    logic [31:0] hits[$];
    int i, k, m, tot;
    bit aborted;
    m = 0;
    tot = 0;
    aborted = 0;
    ecyc = -1;
    for (int j = 0; j < n; j++) hits.push_back($urandom);
    @(posedge clock);
    #1;
    i_roi       = next_roi;
    i_roi_valid = 1'b1;
    i_roi_af    = (af_pct > 0) && ($urandom_range(0, 99) < af_pct);
    i_hit_valid = (n > 0);
    i_hit       = (n > 0) ? hits[0] : 32'd0;
    i_hit_last  = (n == 1);
    roi_hs      = -1;
    for (int b = 0; b < 300; b++) begin
      @(negedge clock);
      chk("hit_ready_outside_hits", {63'b0, o_hit_ready}, 64'd0);
      if (i_roi_af) chk("roi_ready_af", {63'b0, o_roi_ready}, 64'd0);
      if (o_roi_ready) begin
        roi_hs = cyc;
        break;
      end
      @(posedge clock);
      #1;
      i_roi_af = (af_pct > 0) && ($urandom_range(0, 99) < af_pct);
    end
    if (roi_hs < 0) begin
      checks++;
      errors++;
      $display("FAIL roi_accept: ROI not accepted within 300 cycles");
      i_roi_valid = 1'b0;
      i_hit_valid = 1'b0;
      return;
    end
    push_exp(0, next_roi, 0, 1'b0, 1'b0);
    if (n == 0) push_exp(2, 32'd0, 0, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    i_roi_af    = 1'b0;
    i_roi_valid = hold_roi;
    next_roi    = $urandom;
    i_roi       = next_roi;
    i = 0;
    k = 0;
    while (i < n && k < 3000) begin
      i_hit_af    = af_burst ? (k >= 3 && k < 13) : ($urandom_range(0, 99) < af_pct);
      i_hit_valid = ($urandom_range(0, 99) >= gap_pct);
      i_hit       = hits[i];
      i_hit_last  = (i == n - 1);
      @(negedge clock);
      chk("hit_ready", {63'b0, o_hit_ready}, {63'b0, ~i_hit_af});
      if (i_hit_valid && o_hit_ready) begin
        tot++;
        if (m < MAX_HITS) begin
          push_exp(1, hits[i], 0, 1'b0, 1'b0);
          m++;
        end
        if (i == n - 1) push_exp(2, 32'd0, m, (tot > MAX_HITS), 1'b0);
        i++;
        if (tot == abort_after) begin
          @(posedge clock);
          #1;
          @(negedge clock);
          #1;
          resetbar = 1'b0;
          #1;
          chk("rst_roi", 64'(roi), 64'd0);
          chk("rst_roi_we", {63'b0, roi_we}, 64'd0);
          chk("rst_mdt_hit", 64'(mdt_hit), 64'd0);
          chk("rst_mdt_hit_we", {63'b0, mdt_hit_we}, 64'd0);
          chk("rst_eof", {63'b0, o_eof}, 64'd0);
          chk("rst_hit_count", 64'(o_hit_count), 64'd0);
          chk("rst_overflow", {63'b0, o_overflow}, 64'd0);
          chk("rst_timeout", {63'b0, o_timeout}, 64'd0);
          chk("rst_busy", {63'b0, o_busy}, 64'd0);
          exp_q.delete();
          aborted = 1;
          break;
        end
      end
      @(posedge clock);
      #1;
      k++;
    end
    i_hit_valid = 1'b0;
    i_hit_af    = 1'b0;
    i_hit_last  = 1'b0;
    if (aborted) return;
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL hit_accept: only %0d of %0d hits accepted", i, n);
    end
    wait_eof((n == 0) ? TIMEOUT + 50 : 40, ecyc);
  endtask

  initial begin
    int hs, e, hs2, e2, prev_e;
    resetbar    = 1'b0;
    i_roi       = '0;
    i_roi_valid = 1'b0;
    i_hit       = '0;
    i_hit_valid = 1'b0;
    i_hit_last  = 1'b0;
    i_roi_af    = 1'b0;
    i_hit_af    = 1'b0;
    next_roi    = $urandom;
    repeat (3) @(negedge clock);
    chk("reset_busy", {63'b0, o_busy}, 64'd0);
    chk("reset_hit_count", 64'(o_hit_count), 64'd0);
    chk("reset_eof", {63'b0, o_eof}, 64'd0);
    chk("reset_roi_ready", {63'b0, o_roi_ready}, 64'd1);
    resetbar = 1'b1;

    // Three hits, no stalls: ROI handshake at c, hit strobes c+2..c+4, o_eof at c+5.
    send_event(3, 0, 0, 1'b0, 1'b0, -1, hs, e);
    chk("t1_eof_latency", 64'(e - hs), 64'd5);
    chk("t1_hit_count", 64'(o_hit_count), 64'd3);
    chk("t1_overflow", {63'b0, o_overflow}, 64'd0);

    // 40 hits: first 32 written, rest consumed and dropped.
    send_event(40, 0, 0, 1'b0, 1'b0, -1, hs, e);
    chk("t2_hit_count", 64'(o_hit_count), 64'd32);
    chk("t2_overflow", {63'b0, o_overflow}, 64'd1);

    // Almost-full held for 10 cycles mid-burst.
    send_event(12, 0, 0, 1'b1, 1'b0, -1, hs, e);
    chk("t3_hit_count", 64'(o_hit_count), 64'd12);

    // No hits: timeout closes the event; ROI kept valid throughout HITS and GAP.
    send_event(0, 0, 0, 1'b0, 1'b1, -1, hs, e);
    chk("t4_timeout_latency", 64'(e - hs), 64'(TIMEOUT + 2));
    chk("t4_timeout_pulse", {63'b0, o_timeout}, 64'd1);
    chk("t4_zero_count", 64'(o_hit_count), 64'd0);
    send_event(2, 0, 0, 1'b0, 1'b0, -1, hs2, e2);
    chk("t4_gap_accept", 64'(hs2 - e), 64'(EOF_GAP + 1));

    // Reset after the 2nd hit of a 5-hit event, then a clean 2-hit event.
    send_event(5, 0, 0, 1'b0, 1'b0, 2, hs, e);
    repeat (2) @(negedge clock);
    chk("t5_no_eof_in_reset", {63'b0, o_eof}, 64'd0);
    resetbar = 1'b1;
    send_event(2, 0, 0, 1'b0, 1'b0, -1, hs, e);
    chk("t5_hit_count", 64'(o_hit_count), 64'd2);

    // Back-to-back events with ROI valid held high.
    prev_e = e;
    for (int j = 0; j < 3; j++) begin
      send_event(4, 0, 0, 1'b0, (j < 2), -1, hs, e);
      if (j > 0) chk("t6_back_to_back_accept", 64'(hs - prev_e), 64'(EOF_GAP + 1));
      prev_e = e;
    end

    // Random traffic: bubbles, almost-full throttling, overflow-sized bursts.
    for (int j = 0; j < 25; j++) begin
      send_event($urandom_range(1, 45), $urandom_range(0, 40), $urandom_range(0, 30), 1'b0,
                 (j < 24) && ($urandom_range(0, 1) == 1), -1, hs, e);
    end

    i_roi_valid = 1'b0;
    repeat (10) @(negedge clock);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
